// File: rtl/pwm_duty_decoder.sv
// Receive-side PWM duty decoder: synchronises the Pulse line, aligns to the frame-start
// rising edge and publishes the count of high cycles per 2^W-cycle frame with lock status.
module pwm_duty_decoder #(
  parameter int W           = 6,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic         sysclk,
  input  logic         rst_n,
  input  logic         Pulse_In,
  output logic [W-1:0] Duty,
  output logic         Duty_Valid,
  output logic         Locked,
  output logic         Stuck,
  output logic         Lock_Err
);

  localparam logic [W-1:0] PHASE_MAX = '1;
  localparam logic [W:0]   FULL      = {1'b1, {W{1'b0}}};
  localparam logic [2:0]   LOCK_N    = 3'(LOCK_FRAMES);

  typedef enum logic {
    ST_ACQUIRE,
    ST_LOCKED
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_dly_q, s_dly_d;
  logic [W-1:0]           phase_q, phase_d;
  logic [W:0]             high_cnt_q, high_cnt_d;
  logic [2:0]             clean_cnt_q, clean_cnt_d;
  logic [W-1:0]           duty_q, duty_d;
  logic                   duty_valid_q, duty_valid_d;
  logic                   locked_q, locked_d;
  logic                   stuck_q, stuck_d;
  logic                   lock_err_q, lock_err_d;

  logic       s;
  logic       rise;
  logic [W:0] total;

  always_comb begin
    s     = sync_q[SYNC_STAGES-1];
    rise  = s & ~s_dly_q;
    total = high_cnt_q + {{W{1'b0}}, s};

    // NOTE: every _d is given a default before any branch so no latch can be inferred.
    state_d      = state_q;
    sync_d       = {sync_q[SYNC_STAGES-2:0], Pulse_In};
    s_dly_d      = s;
    phase_d      = phase_q + W'(1);
    high_cnt_d   = high_cnt_q;
    clean_cnt_d  = clean_cnt_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    locked_d     = locked_q;
    stuck_d      = stuck_q;
    lock_err_d   = 1'b0;

    case (state_q)
      ST_ACQUIRE: begin
        if (rise) begin
          // The rising sample itself is phase 0 of the first aligned frame.
          state_d    = ST_LOCKED;
          phase_d    = W'(1);
          high_cnt_d = (W+1)'(1);
        end else if (phase_q == PHASE_MAX) begin
          duty_d       = s ? PHASE_MAX : '0;
          stuck_d      = s;
          duty_valid_d = 1'b1;
        end
      end

      ST_LOCKED: begin
        high_cnt_d = total;
        if (rise && (phase_q != '0)) begin
          lock_err_d  = 1'b1;
          locked_d    = 1'b0;
          clean_cnt_d = '0;
          phase_d     = W'(1);
          high_cnt_d  = (W+1)'(1);
        end else if (phase_q == PHASE_MAX) begin
          duty_d       = (total == FULL) ? PHASE_MAX : total[W-1:0];
          stuck_d      = (total == FULL);
          duty_valid_d = 1'b1;
          high_cnt_d   = '0;
          // A saturated frame carries no edge, so it cannot confirm alignment.
          if (total == FULL) begin
            clean_cnt_d = '0;
          end else if (clean_cnt_q < LOCK_N) begin
            clean_cnt_d = clean_cnt_q + 3'd1;
          end
          if (clean_cnt_d >= LOCK_N) begin
            locked_d = 1'b1;
          end
        end
      end

      default: state_d = ST_ACQUIRE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACQUIRE;
      sync_q       <= '0;
      s_dly_q      <= 1'b0;
      phase_q      <= '0;
      high_cnt_q   <= '0;
      clean_cnt_q  <= '0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      stuck_q      <= 1'b0;
      lock_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      s_dly_q      <= s_dly_d;
      phase_q      <= phase_d;
      high_cnt_q   <= high_cnt_d;
      clean_cnt_q  <= clean_cnt_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      locked_q     <= locked_d;
      stuck_q      <= stuck_d;
      lock_err_q   <= lock_err_d;
    end
  end

  assign Duty       = duty_q;
  assign Duty_Valid = duty_valid_q;
  assign Locked     = locked_q;
  assign Stuck      = stuck_q;
  assign Lock_Err   = lock_err_q;

endmodule
